// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit chain.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decimal digit of the stopwatch count; wraps 9 -> 0 and flags the carry into the next digit.
module stopwatch_ctrl_bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_clr,
  output logic [DIGIT_W-1:0] o_q,
  output logic               o_carry
);

  logic [DIGIT_W-1:0] r_q;

  // Synchronous clear outranks counting so a clear from PAUSE always lands on zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + DIGIT_W'(1);
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_en && (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: FSM, tick prescaler, BCD digit chain, lap snapshot and sticky overflow.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int DIGITS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start_stop,
  input  logic                        i_lap,
  input  logic                        i_clear,
  output logic [DIGIT_W*DIGITS-1:0]   o_display,
  output logic                        o_running,
  output logic                        o_lap_active,
  output logic                        o_overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t                      r_state;
  logic [PW-1:0]               r_presc;
  logic [DIGIT_W*DIGITS-1:0]   r_snap;
  logic                        r_running;
  logic                        r_lap_active;
  logic                        r_overflow;

  logic                        w_counting;
  logic                        w_tick;
  logic                        w_clear_ok;
  logic                        w_lap_enter;
  logic                        w_wrap;
  logic [DIGIT_W*DIGITS-1:0]   w_count;

  assign w_counting  = (r_state == RUN) || (r_state == LAP);
  assign w_tick      = w_counting && (r_presc == TICK_LAST);
  // start_stop wins over lap and clear, so the lower-priority pulses only act when it is absent.
  assign w_clear_ok  = (r_state == PAUSE) && i_clear && !i_start_stop;
  assign w_lap_enter = (r_state == RUN) && i_lap && !i_start_stop;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic w_en;
    logic w_carry;
    if (i == 0) begin : g_first
      assign w_en = w_tick;
    end else begin : g_next
      assign w_en = g_digit[i-1].w_carry;
    end
    stopwatch_ctrl_bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_clr   (w_clear_ok),
      .o_q     (w_count[i*DIGIT_W +: DIGIT_W]),
      .o_carry (w_carry)
    );
  end

  assign w_wrap = g_digit[DIGITS-1].w_carry;

  // Outputs are updated together with the state so they reflect the new state right after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start_stop) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (i_start_stop) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (i_lap) begin
            r_state      <= LAP;
            r_lap_active <= 1'b1;
          end
        end
        LAP: begin
          if (i_start_stop) begin
            r_state      <= PAUSE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
          end else if (i_lap) begin
            r_state      <= RUN;
            r_lap_active <= 1'b0;
          end
        end
        PAUSE: begin
          if (i_start_stop) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (i_clear) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_running    <= 1'b0;
          r_lap_active <= 1'b0;
        end
      endcase
    end
  end

  // PAUSE keeps the prescaler phase so a resumed run finishes the interrupted tick period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end else if ((r_state == IDLE) || w_clear_ok) begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_lap_enter) begin
        r_snap <= w_count;
      end
      if (w_clear_ok) begin
        r_overflow <= 1'b0;
      end else if (w_wrap) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_display    = r_lap_active ? r_snap : w_count;
  assign o_running    = r_running;
  assign o_lap_active = r_lap_active;
  assign o_overflow   = r_overflow;

endmodule
